// File: rtl/wbq_pkg.sv
// Shared types for the write-back queue: the queued entry, register count and starvation FSM states.
package wbq_pkg;

    localparam int WBQ_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic                  fpoint;
        logic [4:0]            rd;
        logic [WBQ_DATA_W-1:0] data;
    } wb_entry_t;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } wbq_state_t;

    // Integer r0 is hard-wired to zero, so writes and reservations to it are meaningless.
    function automatic logic is_int_r0(input logic fpoint, input logic [4:0] rd);
        return !fpoint && (rd == 5'd0);
    endfunction

endpackage

// File: rtl/wbq_fifo.sv
// Circular FIFO of wb_entry_t with a combinational head view, so the consumer can
// present and pop the oldest entry in the same cycle.
module wbq_fifo
    import wbq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t wr_entry,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t          mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push;
    logic               do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    // Storage carries no reset: stale slots are never visible once the count is cleared.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue for long-latency results, sharing the register-file write port with the datapath.
// Optional same-cycle bypass of an empty queue is enabled by defining WBQ_BYPASS_EN.
module wb_queue
    import wbq_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int DATA_W    = WBQ_DATA_W,
    parameter int STALL_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_fpoint,
    input  logic [4:0]        in_reg,
    input  logic [DATA_W-1:0] in_data,
    input  logic              dp_write,
    input  logic              rsv_valid,
    input  logic              rsv_fpoint,
    input  logic [4:0]        rsv_reg,
    output logic              wb_write,
    output logic              wb_regdst,
    output logic              wb_fpoint,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [31:0]       busy_int,
    output logic [31:0]       busy_fp,
    output logic              stall_req
);

    localparam logic [0:0] S_RUN   = RUN;
    localparam logic [0:0] S_STALL = STALL;
    localparam int         CNT_W   = $clog2(STALL_MAX) + 1;

    wb_entry_t          in_entry;
    wb_entry_t          head;
    logic               full;
    logic               empty;
    logic               push_fire;
    logic               in_is_r0;
    logic               bypass;
    logic               fifo_push;
    logic               fifo_pop;

    logic [NUM_REGS-1:0] busy_int_q, busy_int_d;
    logic [NUM_REGS-1:0] busy_fp_q, busy_fp_d;
    logic [NUM_REGS-1:0] set_int, set_fp, clr_int, clr_fp;

    logic [0:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    assign in_entry  = '{fpoint: in_fpoint, rd: in_reg, data: in_data};
    assign in_ready  = !full;
    assign push_fire = in_valid && in_ready;
    assign in_is_r0  = is_int_r0(in_fpoint, in_reg);
    assign fifo_pop  = !empty && !dp_write;

`ifdef WBQ_BYPASS_EN
    assign bypass = push_fire && !in_is_r0 && empty && !dp_write;
`else
    assign bypass = 1'b0;
`endif

    assign fifo_push = push_fire && !in_is_r0 && !bypass;

    wbq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .wr_entry (in_entry),
        .head     (head),
        .full     (full),
        .empty    (empty)
    );

    // Port mux: queued head when the datapath is idle, else (bypass) the live input.
    always_comb begin
        wb_write  = 1'b0;
        wb_fpoint = 1'b0;
        wb_rd     = '0;
        wb_data   = '0;
        if (fifo_pop) begin
            wb_write  = 1'b1;
            wb_fpoint = head.fpoint;
            wb_rd     = head.rd;
            wb_data   = head.data;
        end else if (bypass) begin
            wb_write  = 1'b1;
            wb_fpoint = in_fpoint;
            wb_rd     = in_reg;
            wb_data   = in_data;
        end
    end

    assign wb_regdst = 1'b1;

    // Clears follow the actual write, so bypassed results release their register too.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
            assign set_int[gi] = rsv_valid && !rsv_fpoint && (rsv_reg == 5'(gi)) && (gi != 0);
            assign set_fp[gi]  = rsv_valid && rsv_fpoint && (rsv_reg == 5'(gi));
            assign clr_int[gi] = wb_write && !wb_fpoint && (wb_rd == 5'(gi));
            assign clr_fp[gi]  = wb_write && wb_fpoint && (wb_rd == 5'(gi));
        end
    endgenerate

    assign busy_int_d = (busy_int_q & ~clr_int) | set_int;
    assign busy_fp_d  = (busy_fp_q & ~clr_fp) | set_fp;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RUN: begin
                if (fifo_pop || empty) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(STALL_MAX - 1)) begin
                    state_d = S_STALL;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STALL: begin
                if (fifo_pop || empty) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_int_q <= '0;
            busy_fp_q  <= '0;
            state_q    <= S_RUN;
            cnt_q      <= '0;
        end else begin
            busy_int_q <= busy_int_d;
            busy_fp_q  <= busy_fp_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
        end
    end

    assign busy_int  = busy_int_q;
    assign busy_fp   = busy_fp_q;
    assign stall_req = (state_q == S_STALL);

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: stimulus queues expected writes, a negedge monitor compares them.
module tb_wb_queue;

`ifdef WBQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_fpoint;
    logic [4:0]  in_reg;
    logic [31:0] in_data;
    logic        dp_write, rsv_valid, rsv_fpoint;
    logic [4:0]  rsv_reg;
    logic        wb_write, wb_regdst, wb_fpoint;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] busy_int, busy_fp;
    logic        stall_req;

    int checks   = 0;
    int failures = 0;
    logic [37:0] exp_q[$];

    always #5 clk = ~clk;

    wb_queue #(.DEPTH(4), .DATA_W(32), .STALL_MAX(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_fpoint  (in_fpoint),
        .in_reg     (in_reg),
        .in_data    (in_data),
        .dp_write   (dp_write),
        .rsv_valid  (rsv_valid),
        .rsv_fpoint (rsv_fpoint),
        .rsv_reg    (rsv_reg),
        .wb_write   (wb_write),
        .wb_regdst  (wb_regdst),
        .wb_fpoint  (wb_fpoint),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .busy_int   (busy_int),
        .busy_fp    (busy_fp),
        .stall_req  (stall_req)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, got, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_in(input logic fp, input logic [4:0] rd, input logic [31:0] d);
        in_valid  = 1'b1;
        in_fpoint = fp;
        in_reg    = rd;
        in_data   = d;
        if (!(fp == 1'b0 && rd == 5'd0)) exp_q.push_back({fp, rd, d});
    endtask

    // Monitor: every register-file write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && wb_write === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL wb_unexpected got fp=%0d rd=%0d data=%h want no write", wb_fpoint, wb_rd, wb_data);
            end else begin
                logic [37:0] e;
                e = exp_q.pop_front();
                if ({wb_fpoint, wb_rd, wb_data} !== e)
                    failures++;
                if ({wb_fpoint, wb_rd, wb_data} !== e)
                    $display("FAIL wb_entry got fp=%0d rd=%0d data=%h want fp=%0d rd=%0d data=%h",
                             wb_fpoint, wb_rd, wb_data, e[37], e[36:32], e[31:0]);
                $display("write fp=%0d rd=%0d data=%h", wb_fpoint, wb_rd, wb_data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 0; in_fpoint = 0; in_reg = 0; in_data = 0;
        dp_write = 0; rsv_valid = 0; rsv_fpoint = 0; rsv_reg = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_wb_write", 32'(wb_write), 32'd0);
        chk("rst_wb_regdst", 32'(wb_regdst), 32'd1);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_busy_int", busy_int, 32'd0);
        chk("rst_busy_fp", busy_fp, 32'd0);
        chk("rst_stall_req", 32'(stall_req), 32'd0);

        // 1: single result, minimum latency
        step();
        push_in(1'b0, 5'd5, 32'hDEADBEEF);
        @(negedge clk);
        chk("t1_push_cycle_write", 32'(wb_write), 32'(BYP));
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t1_next_cycle_write", 32'(wb_write), 32'(!BYP));
        chk("t1_regdst", 32'(wb_regdst), 32'd1);
        step();
        @(negedge clk);
        chk("t1_empty_after", 32'(wb_write), 32'd0);

        // 2: fill while blocked, then drain in order
        step();
        dp_write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_in(1'(i % 2), 5'(i + 1), 32'h100 + 32'(i));
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("t2_full_in_ready", 32'(in_ready), 32'd0);
        chk("t2_blocked_write", 32'(wb_write), 32'd0);
        step();
        dp_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_drain_write", 32'(wb_write), 32'd1);
            step();
        end
        @(negedge clk);
        chk("t2_drained", 32'(wb_write), 32'd0);

        // 3: reservation cleared by pop, then set-wins on the pop cycle
        step();
        rsv_valid = 1'b1; rsv_fpoint = 1'b1; rsv_reg = 5'd3;
        step();
        rsv_valid = 1'b0;
        @(negedge clk);
        chk("t3_rsv_set", 32'(busy_fp[3]), 32'd1);
        step();
        dp_write = 1'b1;
        push_in(1'b1, 5'd3, 32'h33);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t3_busy_queued", 32'(busy_fp[3]), 32'd1);
        step();
        dp_write = 1'b0;
        @(negedge clk);
        chk("t3_pop_write", 32'(wb_write), 32'd1);
        chk("t3_busy_pop_cycle", 32'(busy_fp[3]), 32'd1);
        step();
        @(negedge clk);
        chk("t3_busy_cleared", busy_fp, 32'd0);
        step();
        dp_write = 1'b1;
        push_in(1'b1, 5'd3, 32'h44);
        step();
        in_valid = 1'b0;
        dp_write = 1'b0;
        rsv_valid = 1'b1; rsv_fpoint = 1'b1; rsv_reg = 5'd3;
        @(negedge clk);
        chk("t3_pop2_write", 32'(wb_write), 32'd1);
        step();
        rsv_valid = 1'b0;
        @(negedge clk);
        chk("t3_set_wins", 32'(busy_fp[3]), 32'd1);

        // 4: starvation -> stall_req after 8 blocked cycles
        step();
        dp_write = 1'b1;
        push_in(1'b0, 5'd9, 32'h99);
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk($sformatf("t4_stall_cyc%0d", k), 32'(stall_req), 32'(k >= 9));
            step();
        end
        dp_write = 1'b0;
        @(negedge clk);
        chk("t4_pop_write", 32'(wb_write), 32'd1);
        chk("t4_stall_pop_cycle", 32'(stall_req), 32'd1);
        step();
        @(negedge clk);
        chk("t4_stall_released", 32'(stall_req), 32'd0);

        // 5: int r0 discarded, then async reset drops queued entries
        step();
        push_in(1'b0, 5'd0, 32'hBAD);
        rsv_valid = 1'b1; rsv_fpoint = 1'b0; rsv_reg = 5'd0;
        @(negedge clk);
        chk("t5_r0_push_cycle", 32'(wb_write), 32'd0);
        step();
        in_valid = 1'b0;
        rsv_valid = 1'b0;
        @(negedge clk);
        chk("t5_r0_no_write", 32'(wb_write), 32'd0);
        chk("t5_busy_int0", 32'(busy_int[0]), 32'd0);
        step();
        dp_write = 1'b1;
        rsv_valid = 1'b1; rsv_fpoint = 1'b0; rsv_reg = 5'd10;
        for (int i = 0; i < 3; i++) begin
            push_in(1'b0, 5'(20 + i), 32'(i));
            step();
        end
        in_valid = 1'b0;
        rsv_valid = 1'b0;
        @(negedge clk);
        chk("t5_busy_int10", 32'(busy_int[10]), 32'd1);
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk("t5_rst_in_ready", 32'(in_ready), 32'd1);
        chk("t5_rst_busy_int", busy_int, 32'd0);
        chk("t5_rst_busy_fp", busy_fp, 32'd0);
        step();
        rst = 1'b0;
        dp_write = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_no_write_after_rst", 32'(wb_write), 32'd0);
            step();
        end

        // 6: latency of a push into an empty queue
        push_in(1'b0, 5'd7, 32'h1234);
        @(negedge clk);
        chk("t6_push_cycle_write", 32'(wb_write), 32'(BYP));
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t6_next_cycle_write", 32'(wb_write), 32'(!BYP));
        step();
        @(negedge clk);
        chk("t6_idle", 32'(wb_write), 32'd0);
        chk("t6_busy_int", busy_int, 32'd0);

        chk("end_expect_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
